// File: rtl/pid_pkg.sv
// Shared types and saturation helpers for the PID sum sequencer.
package pid_pkg;

    localparam int unsigned PID_DW = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_INT  = 3'd1,
        S_PADD = 3'd2,
        S_DADD = 3'd3,
        S_OUT  = 3'd4
    } pid_state_e;

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(PID_DW);
    localparam longint SAT_MIN = sat_min(PID_DW);

    // Overflow of the exact (unclamped) sum of two w-bit signed operands.
    function automatic logic sat_event(input longint a, input longint b, input int unsigned w);
        longint s;
        s = a + b;
        return (s > sat_max(w)) || (s < sat_min(w));
    endfunction

endpackage

// File: rtl/saturating_adder_signed.sv
// Combinational signed adder that clamps to the representable range instead of wrapping.
module saturating_adder_signed #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] sum_c_o
);

    localparam int unsigned EW = DATA_WIDTH + 1;

    logic signed [EW-1:0] exact_c;

    // Top two bits of the exact sum disagree exactly when the result does not fit.
    always_comb begin
        exact_c = EW'(a_i) + EW'(b_i);
        if (exact_c[EW-1] != exact_c[EW-2]) begin
            sum_c_o = exact_c[EW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            sum_c_o = exact_c[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pid_sum_sequencer.sv
// Time-shares one saturating adder to form u = sat(sat(sat(I + i_incr) + P) + D),
// owning the integrator so it clamps instead of winding up past full scale.
module pid_sum_sequencer
    import pid_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PID_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] p_term,
    input  logic [DATA_WIDTH-1:0] i_incr,
    input  logic [DATA_WIDTH-1:0] d_term,
    input  logic                  integ_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] u_out,
    output logic [DATA_WIDTH-1:0] integ_out,
    output logic                  sat_flag
);

    pid_state_e state_q;

    logic signed [DATA_WIDTH-1:0] p_q;
    logic signed [DATA_WIDTH-1:0] i_q;
    logic signed [DATA_WIDTH-1:0] d_q;
    logic signed [DATA_WIDTH-1:0] integ_q;
    logic signed [DATA_WIDTH-1:0] acc_q;
    logic signed [DATA_WIDTH-1:0] u_q;
    logic signed [DATA_WIDTH-1:0] integ_out_q;
    logic                         sat_acc_q;
    logic                         sat_q;
    logic                         clr_pend_q;
    logic                         in_ready_q;
    logic                         out_valid_q;

    logic signed [DATA_WIDTH-1:0] add_a_c;
    logic signed [DATA_WIDTH-1:0] add_b_c;
    logic signed [DATA_WIDTH-1:0] sum_c;
    logic                         sat_ev_c;
    logic                         accept_c;
    logic                         clr_defer_c;

    assign accept_c    = (state_q == IDLE) && in_valid && in_ready_q;
    // A clear in IDLE without a handshake acts at once; everywhere else it waits for the next S_INT.
    assign clr_defer_c = integ_clr && !((state_q == IDLE) && !accept_c);

    // Operand selection depends only on registered state, never on live inputs.
    always_comb begin
        add_a_c = '0;
        add_b_c = '0;
        case (state_q)
            S_INT: begin
                add_a_c = clr_pend_q ? '0 : integ_q;
                add_b_c = i_q;
            end
            S_PADD: begin
                add_a_c = p_q;
                add_b_c = integ_q;
            end
            S_DADD: begin
                add_a_c = acc_q;
                add_b_c = d_q;
            end
            default: begin
                add_a_c = '0;
                add_b_c = '0;
            end
        endcase
    end

    assign sat_ev_c = sat_event(longint'(add_a_c), longint'(add_b_c), DATA_WIDTH);

    saturating_adder_signed #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .a_i     (add_a_c),
        .b_i     (add_b_c),
        .sum_c_o (sum_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            p_q         <= '0;
            i_q         <= '0;
            d_q         <= '0;
            integ_q     <= '0;
            acc_q       <= '0;
            u_q         <= '0;
            integ_out_q <= '0;
            sat_acc_q   <= 1'b0;
            sat_q       <= 1'b0;
            clr_pend_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (clr_defer_c) begin
                clr_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        p_q        <= p_term;
                        i_q        <= i_incr;
                        d_q        <= d_term;
                        in_ready_q <= 1'b0;
                        state_q    <= S_INT;
                    end else begin
                        in_ready_q <= 1'b1;
                        if (integ_clr) begin
                            integ_q <= '0;
                        end
                    end
                end
                S_INT: begin
                    integ_q    <= sum_c;
                    sat_acc_q  <= sat_ev_c;
                    // A clear arriving now belongs to the next sample.
                    clr_pend_q <= integ_clr;
                    state_q    <= S_PADD;
                end
                S_PADD: begin
                    acc_q     <= sum_c;
                    sat_acc_q <= sat_acc_q | sat_ev_c;
                    state_q   <= S_DADD;
                end
                S_DADD: begin
                    u_q         <= sum_c;
                    integ_out_q <= integ_q;
                    sat_q       <= sat_acc_q | sat_ev_c;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign u_out     = u_q;
    assign integ_out = integ_out_q;
    assign sat_flag  = sat_q;

endmodule
